// File: rtl/fsm5_pkg.sv
// Shared encodings for the mod-5 event counter arbiter: arbiter states,
// counter states and small helpers used by the top, the core and the interface.
package fsm5_pkg;
  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, REL = 2'd2} arb_state_e;

  typedef enum logic [2:0] {
    S0 = 3'b000, S1 = 3'b001, S2 = 3'b010, S3 = 3'b011, S4 = 3'b100
  } cnt_state_e;

  function automatic cnt_state_e cnt_next(cnt_state_e s);
    case (s)
      S0:      return S1;
      S1:      return S2;
      S2:      return S3;
      S3:      return S4;
      default: return S0;
    endcase
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/fsm5_arbiter_if.sv
// Requester-side bus of the arbiter: request/event inputs and grant/counter status.
interface fsm5_arbiter_if;
  logic [fsm5_pkg::NUM_REQ-1:0] req;
  logic [fsm5_pkg::NUM_REQ-1:0] in_bus;
  logic [fsm5_pkg::NUM_REQ-1:0] gnt;
  logic [1:0]                   owner;
  logic                         busy;
  logic [2:0]                   cnt;
  logic                         match;

  modport master (output req, in_bus, input gnt, owner, busy, cnt, match);
  modport slave  (input req, in_bus, output gnt, owner, busy, cnt, match);
endinterface

// File: rtl/fsm5_core.sv
// Mod-5 event counter; match flags one cycle after S4 is observed while enabled.
module fsm5_core
  import fsm5_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clr,
  input  logic       en,
  input  logic       ev,
  output cnt_state_e cnt,
  output logic       match
);
  cnt_state_e cnt_nxt;
  logic       match_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt   <= S0;
      match <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      match <= match_nxt;
    end
  end

  // clr wins over ev so a session ending on an event never wraps the count
  always_comb begin
    cnt_nxt   = cnt;
    match_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = S0;
    end else if (en) begin
      match_nxt = (cnt == S4);
      if (ev) cnt_nxt = cnt_next(cnt);
    end
  end
endmodule

// File: rtl/fsm5_arbiter.sv
// Round-robin owner of the shared mod-5 counter with hold-time preemption
// and a one-cycle release state between sessions.
module fsm5_arbiter
  import fsm5_pkg::*;
#(
  parameter int MAX_HOLD = 64
) (
  input logic          CLK,
  input logic          RST_N,
  fsm5_arbiter_if.slave bus
);
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD - 1);

  arb_state_e         state, state_nxt;
  logic [1:0]         owner_r, owner_nxt, ptr_r, ptr_nxt, sel, scan_idx;
  logic [7:0]         hold_r, hold_nxt;
  logic [NUM_REQ-1:0] gnt_r, gnt_nxt;
  logic               core_clr, core_en, core_ev, release_now;
  cnt_state_e         cnt_s;

  // descending scan so the candidate closest to ptr is written last
  always_comb begin
    sel      = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = ptr_r + 2'(k);
      if (bus.req[scan_idx]) sel = scan_idx;
    end
  end

  assign release_now = !bus.req[owner_r] ||
                       ((hold_r == HOLD_MAX) && |(bus.req & ~onehot(owner_r)));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      hold_r  <= '0;
      gnt_r   <= '0;
    end else begin
      state   <= state_nxt;
      owner_r <= owner_nxt;
      ptr_r   <= ptr_nxt;
      hold_r  <= hold_nxt;
      gnt_r   <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner_r;
    ptr_nxt   = ptr_r;
    hold_nxt  = hold_r;
    gnt_nxt   = gnt_r;
    core_clr  = 1'b0;
    core_en   = 1'b0;
    core_ev   = 1'b0;
    case (state)
      IDLE: begin
        core_clr = 1'b1;
        if (|bus.req) begin
          state_nxt = RUN;
          owner_nxt = sel;
          gnt_nxt   = onehot(sel);
          hold_nxt  = '0;
        end
      end
      RUN: begin
        if (release_now) begin
          state_nxt = REL;
          gnt_nxt   = '0;
          core_clr  = 1'b1;
          ptr_nxt   = owner_r + 2'd1;
        end else begin
          core_en = 1'b1;
          core_ev = bus.in_bus[owner_r];
          if (hold_r != HOLD_MAX) hold_nxt = hold_r + 8'd1;
        end
      end
      REL: begin
        state_nxt = IDLE;
        core_clr  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  fsm5_core u_core (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (core_clr),
    .en    (core_en),
    .ev    (core_ev),
    .cnt   (cnt_s),
    .match (bus.match)
  );

  assign bus.gnt   = gnt_r;
  assign bus.owner = owner_r;
  assign bus.busy  = (state == RUN);
  assign bus.cnt   = cnt_s;
endmodule

// File: tb/tb_fsm5_arbiter.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares.
module tb_fsm5_arbiter;
  localparam int MH = 4;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic [2:0] cnt;
    logic       match;
  } exp_t;

  logic CLK, RST_N;
  fsm5_arbiter_if ifc();
  fsm5_arbiter #(.MAX_HOLD(MH)) dut (.CLK(CLK), .RST_N(RST_N), .bus(ifc));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t sb[$];
  int   checks = 0, errors = 0;

  // reference model: session-level view of who holds the counter
  bit m_active, m_releasing;
  int m_owner, m_ptr, m_cnt, m_hold, m_match;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_releasing = 0;
    m_owner = 0; m_ptr = 0; m_cnt = 0; m_hold = 0; m_match = 0;
  endtask

  task automatic model_step(input logic [3:0] req, input logic [3:0] bus);
    int others;
    m_match = 0;
    if (m_releasing) begin
      m_releasing = 0;
      m_ptr = (m_owner + 1) % 4;
    end else if (m_active) begin
      others = req & ~(1 << m_owner);
      if (!req[m_owner] || (m_hold == MH - 1 && others != 0)) begin
        m_active = 0; m_releasing = 1; m_cnt = 0;
      end else begin
        m_match = (m_cnt == 4);
        if (bus[m_owner]) m_cnt = (m_cnt + 1) % 5;
        if (m_hold < MH - 1) m_hold++;
      end
    end else if (req != 0) begin
      for (int k = 3; k >= 0; k--)
        if (req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      m_active = 1; m_cnt = 0; m_hold = 0;
    end
  endtask

  task automatic cycle(input logic [3:0] req, input logic [3:0] bus);
    exp_t e;
    @(negedge CLK);
    ifc.req = req; ifc.in_bus = bus;
    model_step(req, bus);
    e.gnt   = m_active ? 4'(1 << m_owner) : 4'd0;
    e.owner = 2'(m_owner);
    e.busy  = m_active;
    e.cnt   = 3'(m_cnt);
    e.match = 1'(m_match);
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, ifc.gnt, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_cnt"}, ifc.cnt, 0);
    chk({tag, "_match"}, ifc.match, 0);
    chk({tag, "_owner"}, ifc.owner, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("gnt", ifc.gnt, e.gnt);
        chk("busy", ifc.busy, e.busy);
        chk("cnt", ifc.cnt, e.cnt);
        chk("match", ifc.match, e.match);
        if (e.busy) chk("owner", ifc.owner, e.owner);
        chk("gnt_onehot", int'($countones(ifc.gnt) <= 1), 1);
      end
    end
  end

  initial begin : stim
    logic [3:0] r, drop;
    RST_N = 1'b0; ifc.req = '0; ifc.in_bus = '0;
    model_reset();
    #3 chk_zero("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;

    // single requester counting through a wrap
    repeat (7) cycle(4'b0001, 4'b0001);
    repeat (3) cycle(4'b0000, 4'b0000);

    // all request, each owner leaves after 3 RUN cycles
    for (int i = 0; i < 24; i++) begin
      drop = (m_active && m_hold >= 2) ? 4'(1 << m_owner) : 4'd0;
      cycle(4'b1111 & ~drop, 4'($urandom));
    end
    repeat (3) cycle(4'b0000, 4'b0000);

    // timeout preemption, then a lone owner outlasting the timeout
    repeat (12) cycle(4'b0011, 4'($urandom));
    repeat (10) cycle(4'b0001, 4'b0001);
    repeat (3) cycle(4'b0000, 4'b0000);

    // cnt parked at 3 while only non-owner events toggle
    repeat (4) cycle(4'b0001, 4'b0001);
    repeat (5) cycle(4'b0001, 4'b1110);
    repeat (3) cycle(4'b0000, 4'b0000);

    // owner drops req on the same edge it would wrap from 4
    repeat (5) cycle(4'b0001, 4'b0001);
    cycle(4'b0000, 4'b0001);
    repeat (3) cycle(4'b0000, 4'b0000);

    // owner 2 at cnt 4 with match high, then mid-cycle reset
    repeat (5) cycle(4'b0100, 4'b0100);
    cycle(4'b0100, 4'b0000);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1 chk_zero("midreset");
    model_reset();
    #1 RST_N = 1'b1;
    repeat (3) cycle(4'b0100, 4'b0100);
    repeat (2) cycle(4'b0000, 4'b0000);
    repeat (3) cycle(4'b1010, 4'b0010);
    repeat (3) cycle(4'b0000, 4'b0000);

    // randomized traffic with sticky requests
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) r = 4'($urandom);
      cycle(r, 4'($urandom));
    end

    @(posedge CLK); #2;
    chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
